// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host side.
// Holds the transmitter state encoding, command bytes and frame size.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        XFER,
        WAIT_IDLE,
        ERR
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam logic [7:0] PS2_RSP_ACK = 8'hFA;

    localparam int PS2_FRAME_EDGES = 11;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: N-stage synchronizer for PS2_CLK/PS2_DAT plus a
// one-cycle strobe on each falling edge of the synchronized clock.
// Ports: clk, reset (sync, active-high), clk_raw, dat_raw (async pins),
//        clk_s, dat_s (synced levels), fall (clk_s 1->0 strobe).
module ps2_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_raw,
    input  logic dat_raw,
    output logic clk_s,
    output logic dat_s,
    output logic fall
);

    logic [STAGES-1:0] clk_sh;
    logic [STAGES-1:0] dat_sh;
    logic              clk_prev;

    // Idle bus level is high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sh   <= '1;
            dat_sh   <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sh   <= STAGES'({clk_sh, clk_raw});
            dat_sh   <= STAGES'({dat_sh, dat_raw});
            clk_prev <= clk_s;
        end
    end

    assign clk_s = clk_sh[STAGES-1];
    assign dat_s = dat_sh[STAGES-1];
    assign fall  = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Request-to-send, frame shift on device clock falls, line-ACK check.
// Ports: CLOCK_50, reset (sync, active-high), send, command[7:0],
//        ps2_clk_in, ps2_dat_in (raw pins), ps2_clk_oe, ps2_dat_oe
//        (1 = pull low), busy, done (ACK pulse), error (NACK/timeout).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int MAX_IS =
        (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAX_C  =
        (MAX_IS > TIMEOUT_CYCLES) ? MAX_IS : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_C);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    K_LAST   = 4'(PS2_FRAME_EDGES - 1);

    logic clk_s;
    logic dat_s;
    logic fall;

    ps2_line_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (CLOCK_50),
        .reset   (reset),
        .clk_raw (ps2_clk_in),
        .dat_raw (ps2_dat_in),
        .clk_s   (clk_s),
        .dat_s   (dat_s),
        .fall    (fall)
    );

    ps2_state_t    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    k, k_d;
    logic [7:0]    cmd, cmd_d;
    logic          par, par_d;
    logic          dat_q, dat_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            k       <= '0;
            cmd     <= '0;
            par     <= 1'b0;
            dat_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            k       <= k_d;
            cmd     <= cmd_d;
            par     <= par_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        k_d     = k;
        cmd_d   = cmd;
        par_d   = par;
        dat_d   = dat_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (send) begin
                    cmd_d   = command;
                    par_d   = odd_parity(command);
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            START: begin
                if (cnt == SET_LAST) begin
                    cnt_d   = '0;
                    k_d     = '0;
                    dat_d   = 1'b1;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            XFER: begin
                // dat_d lands one cycle after fall, while clk is low.
                if (fall) begin
                    cnt_d = '0;
                    k_d   = k + 1'b1;
                    if (k == K_LAST) begin
                        dat_d   = 1'b0;
                        state_d = dat_s ? ERR : WAIT_IDLE;
                    end else if (k < 4'd8) begin
                        dat_d = ~cmd[k[2:0]];
                    end else if (k == 4'd8) begin
                        dat_d = ~par;
                    end else begin
                        dat_d = 1'b0;
                    end
                end else if (cnt == TO_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt == TO_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ERR: begin
                cnt_d   = '0;
                dat_d   = 1'b0;
                error_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ps2_clk_oe = (state == INHIBIT) || (state == START);
    assign ps2_dat_oe = (state == START) ||
                        ((state == XFER) && dat_q);
    assign busy  = (state != IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench with a PS/2 device model and a
// scoreboard of expected frames/outcomes popped on each done/error.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 60;
    localparam int SET = 5;
    localparam int TO  = 400;

    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_STALL = 2;
    localparam int M_RESET = 3;

    typedef struct {
        bit          is_err;
        logic [10:0] frame;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] command = 8'h00;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;

    logic        dev_clk_low = 1'b0;
    logic        dev_dat_low = 1'b0;
    logic [10:0] cap_frame = '0;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   inh_n = 0;
    int   set_n = 0;
    logic prev_clk_oe = 1'b0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SET),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .send       (send),
        .command    (command),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] c);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(c[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = c[i];
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Scoreboard monitor: every done/error must match the oldest expectation.
    always @(negedge CLOCK_50) begin
        if (!reset && (done || error)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done=%0b error=%0b, none pending",
                         done, error);
            end else begin
                mon_e = sb.pop_front();
                check("outcome_error", int'(error), int'(mon_e.is_err));
                check("outcome_done", int'(done), int'(!mon_e.is_err));
                check("busy_at_pulse", int'(busy), 0);
                check("oe_at_pulse", int'({ps2_clk_oe, ps2_dat_oe}), 0);
                if (done) check("frame", int'(cap_frame), int'(mon_e.frame));
            end
        end
    end

    // Line-phase monitor: inhibit/setup lengths and no driving while idle.
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (!busy) check("idle_release", int'({ps2_clk_oe, ps2_dat_oe}), 0);
            if (ps2_clk_oe && !ps2_dat_oe) begin
                inh_n++;
            end else if (ps2_clk_oe) begin
                set_n++;
            end else if (prev_clk_oe) begin
                check("inhibit_len", inh_n, INH);
                check("setup_len", set_n, SET);
                inh_n = 0;
                set_n = 0;
            end
            prev_clk_oe = ps2_clk_oe;
        end
    end

    task automatic await_error(input int lo, input int hi, input int hp);
        int n;
        n = 0;
        while (!error && n < 2 * TO) begin
            @(negedge CLOCK_50);
            n++;
            if (n == hp) dev_clk_low = 1'b0;
        end
        dev_clk_low = 1'b0;
        if (!error) begin
            bound_fail("timeout_error");
        end else begin
            checks++;
            if (n < lo || n > hi) begin
                errors++;
                $display("FAIL timeout_delay: got %0d cycles, expected %0d..%0d",
                         n, lo, hi);
            end
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic run_frame(input logic [7:0] c, input int mode,
                             input int stop_n, input bit inject);
        exp_t e;
        int   n;
        int   hp;
        hp = int'($urandom_range(15, 25));
        cap_frame = '0;
        if (mode != M_RESET) begin
            e.is_err = (mode != M_ACK);
            e.frame  = ref_frame(c);
            sb.push_back(e);
        end
        command = c;
        send    = 1'b1;
        @(negedge CLOCK_50);
        send    = 1'b0;
        command = 8'($urandom);
        check("busy_rise", int'(busy), 1);
        n = 0;
        while (ps2_clk_oe && n < INH + SET + 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (ps2_clk_oe) begin
            bound_fail("clk_release");
            return;
        end
        if (mode == M_STALL && stop_n == 0) begin
            await_error(TO, TO + 2, hp);
            return;
        end
        for (int i = 1; i <= 11; i++) begin
            repeat (hp - 4) @(negedge CLOCK_50);
            if (i == 11 && mode == M_ACK) dev_dat_low = 1'b1;
            repeat (4) @(negedge CLOCK_50);
            if (i == 1) cap_frame[0] = ps2_dat_in;
            dev_clk_low = 1'b1;
            if (mode == M_STALL && i == stop_n) begin
                await_error(TO + 2, TO + 6, hp);
                return;
            end
            if (mode == M_RESET && i == 4) begin
                @(negedge CLOCK_50);
                reset = 1'b1;
                @(negedge CLOCK_50);
                reset = 1'b0;
                check("rst_clk_oe", int'(ps2_clk_oe), 0);
                check("rst_dat_oe", int'(ps2_dat_oe), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_pulses", int'({done, error}), 0);
                dev_clk_low = 1'b0;
                repeat (hp) @(negedge CLOCK_50);
                return;
            end
            if (inject && i == 3) begin
                send    = 1'b1;
                command = 8'h00;
                @(negedge CLOCK_50);
                send    = 1'b0;
            end
            repeat (hp) @(negedge CLOCK_50);
            if (i <= 10) cap_frame[i] = ps2_dat_in;
            dev_clk_low = 1'b0;
            if (i == 11) dev_dat_low = 1'b0;
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (busy) bound_fail("busy_fall");
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        int r;
        repeat (3) @(negedge CLOCK_50);
        check("reset_clk_oe", int'(ps2_clk_oe), 0);
        check("reset_dat_oe", int'(ps2_dat_oe), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        run_frame(PS2_CMD_SET_LEDS, M_ACK, 0, 1'b0);
        run_frame(8'h00, M_ACK, 0, 1'b0);
        run_frame(PS2_CMD_RESET, M_ACK, 0, 1'b0);
        run_frame(8'h01, M_ACK, 0, 1'b0);
        run_frame(PS2_CMD_ENABLE, M_ACK, 0, 1'b0);
        run_frame(8'h3C, M_NACK, 0, 1'b0);
        run_frame(8'hA5, M_STALL, 0, 1'b0);
        run_frame(8'h5A, M_STALL, 5, 1'b0);
        run_frame(8'h12, M_ACK, 0, 1'b1);
        run_frame(8'h77, M_RESET, 0, 1'b0);
        repeat (10) @(negedge CLOCK_50);
        run_frame(PS2_CMD_RESET, M_ACK, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)
                run_frame(8'($urandom), M_ACK, 0, ($urandom_range(0, 3) == 0));
            else if (r == 7)
                run_frame(8'($urandom), M_NACK, 0, 1'b0);
            else
                run_frame(8'($urandom), M_STALL,
                          int'($urandom_range(0, 10)), 1'b0);
        end

        repeat (20) @(negedge CLOCK_50);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard over the same PS2_CLK/PS2_DAT pair the keyboard receive driver listens on.
- It implements the host request-to-send sequence, clocks out the frame on device-generated clock edges, and checks the device line-ACK.
- It drives open-drain enables only. The top level turns these into pulls on the tri-stated pins. While `busy` is high, the receive driver ignores line activity.

Parameters:
- INHIBIT_CYCLES, 6000: CLOCK_50 cycles the host holds clock low (120 us).
- SETUP_CYCLES, 50: cycles data is held low before clock is released (1 us).
- TIMEOUT_CYCLES, 750000: maximum cycles between device falling edges, and from clock release to the first edge (15 ms).
- SYNC_STAGES, 2: synchronizer depth on both line inputs.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- send  in  1  single-cycle request; ignored while busy
- command  in  8  byte to send; latched on an accepted send
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on a successful ACKed transfer
- error  out  1  one-cycle pulse on NACK or timeout

Behaviour:
- Clock and reset: one clock, CLOCK_50; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0. An assertion of reset mid-transfer releases both lines on the next edge. No done or error pulse is generated for the aborted transfer.
- Line inputs: synchronized through SYNC_STAGES flops. A falling edge is detected as previous synced clk = 1 and current synced clk = 0, giving a one-cycle `fall` strobe.
- States and transitions:
  - IDLE: on `send`, latch `command`, compute parity = ~^command (odd parity), go to INHIBIT. `busy` = 1 from T+1.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles (T+1 .. T+INHIBIT_CYCLES).
  - START: clk_oe = 1 and dat_oe = 1 (start bit 0) for SETUP_CYCLES cycles. Then clk_oe = 0, clear the bit counter and timeout counter, go to XFER.
  - XFER: on each `fall`, increment k (1..11):
    - k = 1..8: dat_oe = ~cmd[k-1], LSB first.
    - k = 9: dat_oe = ~parity.
    - k = 10: dat_oe = 0 (stop bit, line released).
    - k = 11: sample synced dat. 0 means ACK, go to WAIT_IDLE; 1 means NACK, go to ERR.
    - Data changes only in the cycle after `fall` (clock low), so the device samples stable data on its rising edge.
  - WAIT_IDLE: when synced clk = 1 and synced dat = 1, pulse `done`, go to IDLE.
  - ERR: clk_oe = 0, dat_oe = 0, pulse `error`, go to IDLE.
- Timeout: the counter clears on every `fall` and on entry to XFER. If it reaches TIMEOUT_CYCLES in XFER or WAIT_IDLE, go to ERR.
- Busy/strobe timing: `busy` falls in the same cycle that `done` or `error` is high. `send` while busy is dropped, not queued. `command` changes after acceptance have no effect.
- Contention: in IDLE the block never drives the lines. It never asserts clk_oe outside INHIBIT and START.
- Counter widths: sized with $clog2 of the largest of INHIBIT_CYCLES, SETUP_CYCLES and TIMEOUT_CYCLES. The bit counter is 4 bits.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, START, XFER, WAIT_IDLE, ERR.
  - command constants: PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_ENABLE = 8'hF4, PS2_CMD_RESEND = 8'hFE, PS2_CMD_RESET = 8'hFF.
  - response constant: PS2_RSP_ACK = 8'hFA.
  - frame constant: PS2_FRAME_EDGES = 11.
- Sub-module ps2_line_sync: N-stage synchronizer for clk and dat plus falling-edge strobe. The keyboard receive driver can reuse it.

Test Plan:
- send with command = 8'hED; device model clocks 11 falls with a 40 us period and pulls dat low at fall 11 -> clk_oe high for exactly 6000 cycles; bits on rising edges are 0 (start), then 1,0,1,1,0,1,1,1, parity 1, stop 1; `done` pulses once and `error` stays 0.
- Parity coverage -> 8'h00 gives parity 1; 8'hFF gives parity 1; 8'h01 gives parity 0; 8'hF4 gives parity 0.
- NACK: device leaves dat high at fall 11 -> `error` pulses for 1 cycle, no `done`, both oe = 0, `busy` = 0 in that cycle.
- Timeout: device never clocks after release -> `error` pulses TIMEOUT_CYCLES cycles after XFER entry; also repeat with clocking stopped after fall 5.
- send pulsed during XFER with command = 8'h00 -> ignored; frame still carries the original byte; one `done`.
- reset asserted at fall 4 -> next cycle clk_oe = 0, dat_oe = 0, busy = 0, no pulses; a subsequent send of 8'hFF completes normally.
